mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter and sequencer for a single-ported, fixed-latency unified memory shared by the instruction-fetch stage and the data-memory stage of the pipelined RISC-V core. It accepts one access at a time from either requester and drives the memory control signals for exactly LATENCY cycles. It then returns read data with a one-cycle done pulse to the requester that was served. Data accesses have priority, and a starvation counter bounds how long fetch can be locked out.

## Interface
- LATENCY, 2, memory access cycles per transaction (1..15)
- STARVE_LIMIT, 4, consecutive data grants while fetch waits before fetch is forced to win (1..15)

- clk  in  1  clock, posedge
- rst  in  1  reset, asynchronous, active-high
- f_req  in  1  fetch request (read only)
- f_addr  in  32  fetch byte address
- f_gnt  out  1  one-cycle pulse: fetch request accepted
- f_done  out  1  one-cycle pulse: fetch data valid on f_rdata
- f_rdata  out  32  fetch read data, held until next fetch completion
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_gnt  out  1  one-cycle pulse: data request accepted
- d_done  out  1  one-cycle pulse: data access finished
- d_rdata  out  32  load data, held until next load completion
- mem_addr  out  32  latched address of current access
- mem_wdata  out  32  latched store data
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- mem_rdata  in  32  memory read data, valid in last BUSY cycle
- busy  out  1  access in progress

## Operation
- States: IDLE, BUSY. Reset enters IDLE.
- **IDLE:** requests are sampled each cycle.
  - If only one of f_req or d_req is high, that requester wins.
  - If both are high, data wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
  - On a win, at the clock edge: latch addr, wdata and we (fetch: we = 0, wdata unchanged), and latch the owner.
  - The same edge loads the latency counter with LATENCY-1, sets the winner's gnt, and moves to BUSY.
- **BUSY:** mem_read = ~we_latched and mem_write = we_latched, asserted for exactly LATENCY cycles.
  - The counter decrements each cycle.
  - At the edge ending the cycle with counter == 0:
    - for a load, capture mem_rdata into the owner's rdata register;
    - set the owner's done;
    - return to IDLE.
- mem_addr/mem_wdata are driven from the latched registers in every state. Reset value is 0; they change only on a grant.
- Stores leave d_rdata unchanged.
- **starve_cnt** (4 bits), updated at the grant edge:
  - a data grant while f_req is high increments it, saturating at STARVE_LIMIT;
  - a fetch grant clears it;
  - a data grant with f_req low leaves it unchanged.
- **Handshake:**
  - A requester holds req, addr, wdata and we stable from assertion until its done cycle.
  - In the done cycle, req is re-sampled as a new request: a requester with no further access deasserts req combinationally in that cycle.
  - A requester with a back-to-back access keeps req high and presents the new addr/data in that cycle.
- busy = (state == BUSY).

## Timing
- Request sampled in IDLE cycle T:
  - gnt high in T+1;
  - mem_read/mem_write high in T+1..T+LATENCY;
  - done high and rdata valid in T+LATENCY+1.
- The done cycle is an IDLE arbitration cycle. Back-to-back throughput is one access per LATENCY+1 cycles.
- gnt, done, rdata, mem_addr and mem_wdata are registered. mem_read/mem_write decode from registered state only, with no input-to-output combinational path.
- Reset values: f_gnt, d_gnt, f_done, d_done, mem_read, mem_write and busy are 0; f_rdata, d_rdata, mem_addr and mem_wdata are 0; starve_cnt is 0.
- **Reset mid-access:** all outputs go to their reset values asynchronously and the in-flight access is dropped. No done is issued. The first grant after reset release follows the normal IDLE sampling.
- **Simultaneous done and new request:** handled in the same IDLE cycle, per the arbitration rules above.
- **Latency 1:** exactly one BUSY cycle (counter loads 0).

## Test plan
- **Reset:** assert rst with requests active → every output is 0 and busy = 0. After release with no requests, outputs stay 0.
- **Single fetch:** LATENCY=2, f_addr=0x10, mem_rdata=0x00500093 → f_gnt at T+1; mem_read high at T+1..T+2 with mem_addr=0x10; f_done at T+3 with f_rdata=0x00500093.
- **Simultaneous requests:** f_req and d_req (load, addr 0x40) at T → d_gnt T+1, d_done T+3; fetch is arbitrated in T+3, f_gnt T+4, f_done T+6.
- **Store:** d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF → mem_write high for 2 cycles with mem_wdata=0xDEADBEEF; mem_read stays 0; d_done at T+3; d_rdata unchanged.
- **Starvation:** STARVE_LIMIT=4, f_req and d_req held high continuously → 4 data grants, then the 5th grant goes to fetch and starve_cnt returns to 0. The following grant goes to data again.
- **Reset during BUSY:** assert rst in the first BUSY cycle → mem_read drops in the same cycle and no done is issued. After release, a fresh request completes with normal latency.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fetch/data arbiter and fixed-latency sequencer for a single-ported unified memory
// Ports: clk/rst (async active-high); fetch f_req/f_addr -> f_gnt/f_done/f_rdata;
//        data d_req/d_we/d_addr/d_wdata -> d_gnt/d_done/d_rdata;
//        memory mem_addr/mem_wdata/mem_read/mem_write <- mem_rdata; busy while an access runs.
module mem_port_arbiter #(
  parameter int LATENCY      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_done,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  output logic        busy
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t     state;
  logic [3:0] cnt;
  logic [3:0] starve_cnt;
  logic       owner_d;
  logic       we;
  logic       pick_f;
  // fetch wins when alone, or when data has starved it for STARVE_LIMIT grants
  assign pick_f    = f_req & (~d_req | (starve_cnt == 4'(STARVE_LIMIT)));
  assign busy      = (state == BUSY);
  assign mem_read  = busy & ~we;
  assign mem_write = busy & we;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      starve_cnt <= '0;
      owner_d    <= 1'b0;
      we         <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      f_gnt      <= 1'b0;
      d_gnt      <= 1'b0;
      f_done     <= 1'b0;
      d_done     <= 1'b0;
      f_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      f_gnt  <= 1'b0;
      d_gnt  <= 1'b0;
      f_done <= 1'b0;
      d_done <= 1'b0;
      if (state == IDLE) begin
        if (f_req | d_req) begin
          state   <= BUSY;
          cnt     <= 4'(LATENCY - 1);
          owner_d <= ~pick_f;
          if (pick_f) begin
            f_gnt      <= 1'b1;
            we         <= 1'b0;
            mem_addr   <= f_addr;
            starve_cnt <= '0;
          end else begin
            d_gnt     <= 1'b1;
            we        <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            if (f_req && starve_cnt != 4'(STARVE_LIMIT))
              starve_cnt <= starve_cnt + 4'd1;
          end
        end
      end else if (cnt == 4'd0) begin
        state <= IDLE;
        if (owner_d) begin
          d_done <= 1'b1;
          if (!we) d_rdata <= mem_rdata;
        end else begin
          f_done  <= 1'b1;
          f_rdata <= mem_rdata;
        end
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter (LATENCY=2, STARVE_LIMIT=4)
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] f_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic        f_gnt, f_done, d_gnt, d_done, mem_read, mem_write, busy;
  logic [31:0] f_rdata, d_rdata, mem_addr, mem_wdata;
  int          n_cmp = 0;
  int          n_err = 0;
  mem_port_arbiter #(.LATENCY(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_done(f_done), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic next();
    @(posedge clk);
    #1;
  endtask
  logic exp_d [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  initial begin
    f_req = 1'b1;
    d_req = 1'b1;
    next();
    next();
    chk("rst_busy", busy, 0);
    chk("rst_gnt", {f_gnt, d_gnt}, 0);
    chk("rst_done", {f_done, d_done}, 0);
    chk("rst_rw", {mem_read, mem_write}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", f_rdata | d_rdata, 0);
    f_req = 1'b0;
    d_req = 1'b0;
    rst = 1'b0;
    next();
    next();
    chk("idle_busy", busy, 0);
    chk("idle_out", {f_gnt, d_gnt, mem_read, mem_write}, 0);
    chk("idle_addr", mem_addr, 0);
    // single fetch
    f_req = 1'b1; f_addr = 32'h10; mem_rdata = 32'h00500093;
    next();
    chk("f1_gnt", f_gnt, 1);
    chk("f1_read1", mem_read, 1);
    chk("f1_addr", mem_addr, 32'h10);
    chk("f1_busy", busy, 1);
    next();
    chk("f1_gnt_pulse", f_gnt, 0);
    chk("f1_read2", mem_read, 1);
    chk("f1_nodone", f_done, 0);
    next();
    f_req = 1'b0;
    chk("f1_done", f_done, 1);
    chk("f1_rdata", f_rdata, 32'h00500093);
    chk("f1_read_off", mem_read, 0);
    next();
    chk("f1_done_pulse", f_done, 0);
    chk("f1_idle", busy, 0);
    chk("f1_rdata_hold", f_rdata, 32'h00500093);
    // simultaneous: data first, then fetch
    f_req = 1'b1; f_addr = 32'h80; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    mem_rdata = 32'h11111111;
    next();
    chk("sim_dgnt", {f_gnt, d_gnt}, 2'b01);
    chk("sim_daddr", mem_addr, 32'h40);
    next();
    next();
    d_req = 1'b0;
    chk("sim_ddone", d_done, 1);
    chk("sim_drdata", d_rdata, 32'h11111111);
    chk("sim_fnotdone", f_done, 0);
    mem_rdata = 32'h22222222;
    next();
    chk("sim_fgnt", {f_gnt, d_gnt}, 2'b10);
    chk("sim_faddr", mem_addr, 32'h80);
    next();
    next();
    f_req = 1'b0;
    chk("sim_fdone", f_done, 1);
    chk("sim_frdata", f_rdata, 32'h22222222);
    chk("sim_drdata_hold", d_rdata, 32'h11111111);
    next();
    // store
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
    mem_rdata = 32'h33333333;
    next();
    chk("st_gnt", d_gnt, 1);
    chk("st_rw1", {mem_read, mem_write}, 2'b01);
    chk("st_wdata", mem_wdata, 32'hDEADBEEF);
    chk("st_addr", mem_addr, 32'h20);
    next();
    chk("st_rw2", {mem_read, mem_write}, 2'b01);
    next();
    d_req = 1'b0; d_we = 1'b0;
    chk("st_done", d_done, 1);
    chk("st_rdata_kept", d_rdata, 32'h11111111);
    chk("st_rw_off", {mem_read, mem_write}, 0);
    next();
    // starvation: both held; expect D D D D F, then counter cleared so D D D D F again
    f_req = 1'b1; f_addr = 32'h100; d_req = 1'b1; d_addr = 32'h200;
    for (int g = 0; g < 10; g++) begin
      next();
      chk($sformatf("stv_gnt%0d", g), {f_gnt, d_gnt}, exp_d[g] ? 2'b01 : 2'b10);
      next();
      next();
      if (g == 9) begin
        f_req = 1'b0;
        d_req = 1'b0;
      end
    end
    next();
    chk("stv_idle", busy, 0);
    // reset during the first BUSY cycle
    d_req = 1'b1; d_addr = 32'h44;
    next();
    chk("rb_read", mem_read, 1);
    rst = 1'b1;
    #1;
    chk("rb_async_read", mem_read, 0);
    chk("rb_async_busy", busy, 0);
    chk("rb_async_addr", mem_addr, 0);
    chk("rb_async_gnt", d_gnt, 0);
    d_req = 1'b0;
    next();
    rst = 1'b0;
    next();
    chk("rb_nodone1", {f_done, d_done}, 0);
    next();
    chk("rb_nodone2", {f_done, d_done}, 0);
    chk("rb_idle", busy, 0);
    f_req = 1'b1; f_addr = 32'h30; mem_rdata = 32'hCAFEF00D;
    next();
    chk("rb_fgnt", f_gnt, 1);
    chk("rb_faddr", mem_addr, 32'h30);
    next();
    next();
    f_req = 1'b0;
    chk("rb_fdone", f_done, 1);
    chk("rb_frdata", f_rdata, 32'hCAFEF00D);
    next();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
